storage_arbiter: RTL

Shares the single storage_controller request port between two requesters: a read-only instruction-fetch port and a read/write data port (scalar core / vector unit).
Arbitrates round-robin and registers the winning request. Holds address, data, write-enable and byte-enables stable for the whole downstream transaction, then routes the completion back to the owner.
Sits between the core memory interfaces and storage_controller. Blocks new grants while the chip is in programming mode.

---
 rtl/storage_arb_pkg.sv | 12 +
 rtl/storage_arb_watchdog.sv | 30 +++
 rtl/storage_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/storage_arb_pkg.sv
// storage_arb_pkg: shared types and constants for the storage arbiter.
//   state_t        - arbiter FSM states (IDLE / ISSUE / WAIT)
//   owner_t        - which requester owns the in-flight transaction
//   TIMEOUT_POISON - read data returned to the owner when the watchdog fires
package storage_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;

  localparam logic [31:0] TIMEOUT_POISON = 32'hDEAD_BEEF;

endpackage

// File: rtl/storage_arb_watchdog.sv
// storage_arb_watchdog: WAIT-state timeout counter for storage_arbiter.
//   clk, rst  - clock, synchronous active-low reset
//   clear     - zero the counter (asserted the cycle before WAIT is entered)
//   enable    - count this cycle (asserted in every WAIT cycle)
//   expired   - counter has reached LIMIT-1 while enabled
// LIMIT must be at least 2.
module storage_arb_watchdog #(
  parameter int LIMIT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] count;

  assign expired = enable && (count == CW'(LIMIT - 1));

  // Saturates at LIMIT-1; the arbiter leaves WAIT in the expiry cycle anyway.
  always_ff @(posedge clk) begin
    if (!rst)                    count <= '0;
    else if (clear)              count <= '0;
    else if (enable && !expired) count <= count + 1'b1;
  end

endmodule

// File: rtl/storage_arbiter.sv
// storage_arbiter: shares the storage_controller request port between the
// instruction-fetch port (read only) and the data port (read/write).
// Round-robin on ties, registered request held stable for the whole
// downstream transaction, completion routed back to the owner.
//   clk, rst                 - clock, synchronous active-low reset
//   if_req/if_addr           - fetch request (level, held until if_valid)
//   if_rdata/if_valid        - fetch completion
//   d_req/d_we/d_addr/
//   d_wdata/d_be             - data request (level, held until d_valid)
//   d_rdata/d_valid          - data completion (reads and writes)
//   mem_access               - one-cycle issue pulse downstream
//   mem_is_writing/mem_addr/
//   mem_wdata/mem_be         - registered request, stable until after completion
//   mem_rdata/mem_valid      - downstream completion
//   prog_mode                - programming mode: no new grants
//   busy                     - transaction in flight
//   err                      - sticky timeout flag
// Optional feature: define STORAGE_ARB_TIMEOUT_EN to enable the WAIT-state
// watchdog (TIMEOUT_CYCLES); without it WAIT holds indefinitely and err=0.
module storage_arbiter
  import storage_arb_pkg::*;
#(
  parameter int MEM_W          = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req,
  input  logic [31:0]        if_addr,
  output logic [MEM_W-1:0]   if_rdata,
  output logic               if_valid,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [31:0]        d_addr,
  input  logic [MEM_W-1:0]   d_wdata,
  input  logic [MEM_W/8-1:0] d_be,
  output logic [MEM_W-1:0]   d_rdata,
  output logic               d_valid,
  output logic               mem_access,
  output logic               mem_is_writing,
  output logic [31:0]        mem_addr,
  output logic [MEM_W-1:0]   mem_wdata,
  output logic [MEM_W/8-1:0] mem_be,
  input  logic [MEM_W-1:0]   mem_rdata,
  input  logic               mem_valid,
  input  logic               prog_mode,
  output logic               busy,
  output logic               err
);

  state_t             state;
  owner_t             owner;
  owner_t             rr;        // port favoured on the next tie
  logic               gnt;
  owner_t             gnt_own;
  logic               tie;
  logic               timeout;
  logic               finish;
  logic [MEM_W-1:0]   cpl_rdata;

  assign busy = (state != IDLE);

  always_comb begin
    gnt     = 1'b0;
    gnt_own = OWN_IF;
    tie     = if_req && d_req;
    if (state == IDLE && !prog_mode) begin
      if (tie) begin
        gnt     = 1'b1;
        gnt_own = rr;
      end else if (if_req) begin
        gnt     = 1'b1;
        gnt_own = OWN_IF;
      end else if (d_req) begin
        gnt     = 1'b1;
        gnt_own = OWN_D;
      end
    end
  end

`ifdef STORAGE_ARB_TIMEOUT_EN
  logic expired;

  storage_arb_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == ISSUE),
    .enable  (state == WAIT),
    .expired (expired)
  );

  // A real completion in the expiry cycle takes precedence.
  assign timeout = expired && !mem_valid;

  always_ff @(posedge clk) begin
    if (!rst)         err <= 1'b0;
    else if (timeout) err <= 1'b1;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
  assign timeout    = 1'b0;
  assign err        = 1'b0;
`endif

  assign finish = ((state == WAIT) && mem_valid) || timeout;

  always_comb begin
    cpl_rdata = mem_is_writing ? '0 : mem_rdata;
    if (timeout) cpl_rdata = MEM_W'(TIMEOUT_POISON);
  end

  // Gating with rst keeps an aborted transaction from pulsing in the reset cycle.
  assign if_valid = rst && finish && (owner == OWN_IF);
  assign d_valid  = rst && finish && (owner == OWN_D);
  assign if_rdata = if_valid ? cpl_rdata : '0;
  assign d_rdata  = d_valid  ? cpl_rdata : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      owner          <= OWN_IF;
      rr             <= OWN_IF;
      mem_access     <= 1'b0;
      mem_is_writing <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_be         <= '0;
    end else begin
      mem_access <= 1'b0;
      case (state)
        IDLE: if (gnt) begin
          state      <= ISSUE;
          owner      <= gnt_own;
          mem_access <= 1'b1;
          // Pointer only moves when both ports competed.
          if (tie) rr <= (gnt_own == OWN_IF) ? OWN_D : OWN_IF;
          if (gnt_own == OWN_IF) begin
            mem_addr       <= if_addr;
            mem_wdata      <= '0;
            mem_be         <= '1;
            mem_is_writing <= 1'b0;
          end else begin
            mem_addr       <= d_addr;
            mem_wdata      <= d_wdata;
            mem_be         <= d_be;
            mem_is_writing <= d_we;
          end
        end
        ISSUE:   state <= WAIT;
        WAIT:    if (finish) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
